// File: rtl/fetch_unit.sv
// Instruction-fetch front end: fetch PC, req/gnt/rvalid memory handshake,
// a DEPTH-entry prefetch FIFO toward decode, and redirect flushing that
// discards responses belonging to the superseded instruction stream.
module fetch_unit #(
    parameter int unsigned          WORD_SIZE = 32,
    parameter int unsigned          ADDR_SIZE = 10,
    parameter int unsigned          DEPTH     = 4,
    parameter logic [ADDR_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect,
    input  logic [ADDR_SIZE-1:0] redirect_pc,
    output logic                 imem_req,
    output logic [ADDR_SIZE-1:0] imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    output logic                 instr_valid,
    output logic [WORD_SIZE-1:0] instr,
    output logic [ADDR_SIZE-1:0] instr_pc,
    input  logic                 instr_ready
);
    localparam int unsigned          PW           = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned          CW           = $clog2(DEPTH + 1);
    localparam logic [ADDR_SIZE-1:0] PC_STEP      = ADDR_SIZE'(4);
    localparam logic [CW:0]          CREDIT_LIMIT = (CW + 1)'(DEPTH);

    logic [ADDR_SIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_SIZE-1:0] resp_pc_q, resp_pc_d;
    logic                 run_q;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [CW-1:0]        outst_q, outst_d;
    logic [CW-1:0]        stale_q, stale_d;

    logic [WORD_SIZE-1:0] word_q  [DEPTH];
    logic [ADDR_SIZE-1:0] pcbuf_q [DEPTH];

    logic [CW:0] credit_sum;
    logic        accept;
    logic        push;
    logic        pop;

    // Credits count buffered entries plus every transaction still in flight,
    // so a returning word always has a free FIFO slot. Registered counts only:
    // a pop in this cycle frees its credit next cycle.
    assign credit_sum  = {1'b0, count_q} + {1'b0, outst_q};
    assign imem_req    = run_q & (credit_sum < CREDIT_LIMIT);
    assign imem_addr   = fetch_pc_q;
    assign accept      = imem_req & imem_gnt;

    // Head outputs are forced to zero while the FIFO is empty.
    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? word_q[rd_ptr_q]  : '0;
    assign instr_pc    = instr_valid ? pcbuf_q[rd_ptr_q] : '0;

    // A response is kept only if it belongs to the current stream and no
    // redirect is happening this cycle; a redirect also swallows any pop.
    assign push = imem_rvalid & ~redirect & (stale_q == '0);
    assign pop  = instr_valid & instr_ready & ~redirect;

    // Next-state computation for PCs, pointers and the three counters.
    always_comb begin
        fetch_pc_d = accept ? fetch_pc_q + PC_STEP : fetch_pc_q;
        resp_pc_d  = push ? resp_pc_q + PC_STEP : resp_pc_q;
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        outst_d    = outst_q + CW'(accept) - CW'(imem_rvalid);
        stale_d    = stale_q;
        if (imem_rvalid && (stale_q != '0)) begin
            stale_d = stale_q - CW'(1);
        end
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            // Everything still in flight after this edge (including a request
            // accepted this cycle) was issued for the old stream. Stale
            // transactions are a subset of the outstanding ones, so this also
            // accumulates correctly across back-to-back redirects.
            stale_d    = outst_d;
        end
    end

    // Control state; reset drops everything at once, including in-flight credit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            run_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            stale_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            run_q      <= 1'b1;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            stale_q    <= stale_d;
        end
    end

    // FIFO storage: word and its PC written together; contents need no reset
    // because the head outputs are gated by the entry count.
    always_ff @(posedge clk) begin
        if (push) begin
            word_q[wr_ptr_q]  <= imem_rdata;
            pcbuf_q[wr_ptr_q] <= resp_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for stream/stall/release, then
// hand-written sequences for redirects, wrap-around, gnt throttling and async reset.
module tb_fetch_unit;
    localparam int AW = 10;
    localparam int WW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt = 1'b0;
    logic          imem_rvalid = 1'b0;
    logic [WW-1:0] imem_rdata = '0;
    logic          instr_valid;
    logic [WW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready = 1'b0;

    fetch_unit #(
        .WORD_SIZE(WW),
        .ADDR_SIZE(AW),
        .DEPTH    (4),
        .RESET_PC (10'h000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } txn_t;

    typedef struct {
        logic          rdy;
        logic          gnt;
        logic          e_req;
        logic [AW-1:0] e_addr;
        logic          e_valid;
        logic [AW-1:0] e_pc;
    } vec_t;

    txn_t mq[$];
    vec_t tbl[13];
    int   cyc_n    = 0;
    int   lat      = 1;
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [WW-1:0] word_of(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | {22'b0, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic chk_out(input string tag, input logic e_req, input logic [AW-1:0] e_addr,
                           input logic e_valid, input logic [AW-1:0] e_pc);
        chk({tag, ".req"},   32'(imem_req),    32'(e_req));
        chk({tag, ".addr"},  32'(imem_addr),   32'(e_addr));
        chk({tag, ".valid"}, 32'(instr_valid), 32'(e_valid));
        chk({tag, ".pc"},    32'(instr_pc),    32'(e_pc));
        chk({tag, ".instr"}, instr,            e_valid ? word_of(e_pc) : 32'h0);
    endtask

    // Drive one cycle's inputs (called at a falling edge), model the memory,
    // then advance to the next falling edge.
    task automatic step(input logic rdy, input logic gnt, input logic rd, input logic [AW-1:0] rpc);
        cyc_n++;
        instr_ready = rdy;
        imem_gnt    = gnt;
        redirect    = rd;
        redirect_pc = rpc;
        if (mq.size() > 0 && mq[0].due <= cyc_n) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(mq[0].addr);
            mq.delete(0);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        if (imem_req && gnt) mq.push_back('{addr: imem_addr, due: cyc_n + lat});
        @(negedge clk);
    endtask

    // Reset for two cycles; returns at the falling edge where rst is released.
    task automatic do_reset();
        rst         = 1'b1;
        mq.delete();
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int            pops;
        logic [AW-1:0] exp_pc;
        logic          r;
        logic          g;

        tbl[0]  = '{1'b1, 1'b1, 1'b1, 10'h000, 1'b0, 10'h000};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 10'h004, 1'b0, 10'h000};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 10'h008, 1'b1, 10'h000};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 10'h00C, 1'b1, 10'h004};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 10'h010, 1'b1, 10'h004};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 10'h014, 1'b1, 10'h004};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 10'h014, 1'b1, 10'h004};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 10'h014, 1'b1, 10'h004};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 10'h014, 1'b1, 10'h008};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 10'h018, 1'b1, 10'h00C};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 10'h01C, 1'b1, 10'h010};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 10'h020, 1'b1, 10'h014};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 10'h024, 1'b1, 10'h018};

        // Reset state
        @(negedge clk);
        chk_out("reset", 1'b0, 10'h000, 1'b0, 10'h000);

        // Stream, decode stall to full FIFO, release
        lat = 1;
        do_reset();
        step(1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 13; i++) begin
            $display("vec %0d: req=%0b addr=%h valid=%0b pc=%h", i, imem_req, imem_addr, instr_valid, instr_pc);
            chk_out($sformatf("stream%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid, tbl[i].e_pc);
            step(tbl[i].rdy, tbl[i].gnt, 1'b0, '0);
        end

        // Redirect with three stale transactions, 3-cycle memory
        lat = 3;
        do_reset();
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 10'h100);
        chk_out("stale_r1", 1'b1, 10'h100, 1'b0, 10'h000);
        step(1'b1, 1'b1, 1'b0, '0);
        chk("stale_r2.valid", 32'(instr_valid), 32'h0);
        step(1'b1, 1'b1, 1'b0, '0);
        chk("stale_r3.valid", 32'(instr_valid), 32'h0);
        step(1'b1, 1'b1, 1'b0, '0);
        chk("stale_r4.valid", 32'(instr_valid), 32'h0);
        step(1'b1, 1'b1, 1'b0, '0);
        chk_out("stale_first", 1'b0, 10'h110, 1'b1, 10'h100);
        step(1'b1, 1'b1, 1'b0, '0);
        chk_out("stale_second", 1'b1, 10'h110, 1'b1, 10'h104);
        $display("txn redirect-stale: first pc=%h", 10'h100);

        // Redirect coincident with an accepted request and a response
        lat = 1;
        do_reset();
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        chk_out("coin_pre", 1'b1, 10'h008, 1'b1, 10'h000);
        step(1'b1, 1'b1, 1'b1, 10'h200);
        chk_out("coin_r1", 1'b1, 10'h200, 1'b0, 10'h000);
        step(1'b1, 1'b1, 1'b0, '0);
        chk_out("coin_r2", 1'b1, 10'h204, 1'b0, 10'h000);
        step(1'b1, 1'b1, 1'b0, '0);
        chk_out("coin_r3", 1'b1, 10'h208, 1'b1, 10'h200);
        step(1'b1, 1'b1, 1'b0, '0);
        chk_out("coin_r4", 1'b1, 10'h20C, 1'b1, 10'h204);
        $display("txn redirect-coincident: pc=%h", instr_pc);

        // Back-to-back redirects with nothing in flight: last one wins
        do_reset();
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, 10'h040);
        chk("b2b_r1.addr", 32'(imem_addr), 32'h040);
        step(1'b1, 1'b0, 1'b1, 10'h080);
        chk_out("b2b_r2", 1'b1, 10'h080, 1'b0, 10'h000);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        chk_out("b2b_first", 1'b1, 10'h088, 1'b1, 10'h080);
        $display("txn back-to-back: pc=%h", instr_pc);

        // PC wrap-around at the top of the address space
        do_reset();
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, 10'h3F8);
        chk_out("wrap_a", 1'b1, 10'h3F8, 1'b0, 10'h000);
        step(1'b1, 1'b1, 1'b0, '0);
        chk("wrap_b.addr", 32'(imem_addr), 32'h3FC);
        step(1'b1, 1'b1, 1'b0, '0);
        chk_out("wrap_c", 1'b1, 10'h000, 1'b1, 10'h3F8);
        step(1'b1, 1'b1, 1'b0, '0);
        chk_out("wrap_d", 1'b1, 10'h004, 1'b1, 10'h3FC);
        step(1'b1, 1'b1, 1'b0, '0);
        chk_out("wrap_e", 1'b1, 10'h008, 1'b1, 10'h000);
        $display("txn wrap: pc=%h", instr_pc);

        // Random gnt gaps and decode stalls: PCs must stay strictly in order
        lat = 2;
        do_reset();
        step(1'b1, 1'b0, 1'b0, '0);
        exp_pc = '0;
        pops   = 0;
        for (int i = 0; i < 40; i++) begin
            r = ($urandom_range(3) != 0);
            g = 1'($urandom_range(1));
            if (instr_valid && r) begin
                chk($sformatf("thr%0d.pc", i), 32'(instr_pc), 32'(exp_pc));
                chk($sformatf("thr%0d.instr", i), instr, word_of(exp_pc));
                $display("txn pop: pc=%h", instr_pc);
                exp_pc = exp_pc + 10'd4;
                pops++;
            end
            step(r, g, 1'b0, '0);
        end
        chk("thr_progress", 32'(pops >= 5), 32'h1);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("pre_rst.valid", 32'(instr_valid), 32'h1);

        // Asynchronous reset mid-burst: outputs drop before the next clock edge
        #2;
        rst = 1'b1;
        mq.delete();
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 10'h000, 1'b0, 10'h000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        lat = 1;
        step(1'b1, 1'b1, 1'b0, '0);
        chk_out("restart1", 1'b1, 10'h000, 1'b0, 10'h000);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        chk_out("restart3", 1'b1, 10'h008, 1'b1, 10'h000);
        $display("txn restart: pc=%h", instr_pc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
